// File: rtl/lcd_uart_tx_if.sv
// Push-side and status signals of the LCD UART transmitter.
// The serial line itself (txd) travels with them.
interface lcd_uart_tx_if #(
    parameter int FIFO_AW = 4
);
    logic               wr_en;
    logic [7:0]         wr_data;
    logic               clr_ovf;
    logic               full;
    logic               empty;
    logic [FIFO_AW:0]   count;
    logic               ovf;
    logic               busy;
    logic               txd;

    modport master (
        output wr_en, wr_data, clr_ovf,
        input  full, empty, count, ovf, busy, txd
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf,
        output full, empty, count, ovf, busy, txd
    );
endinterface

// File: rtl/lcd_uart_tx.sv
// 8N1 UART transmitter with a byte FIFO, driving the serial LCD link.
// Each bit lasts exactly CLK_DIV clocks; back-to-back frames have no idle gap.
module lcd_uart_tx #(
    parameter int CLK_DIV = 1042,
    parameter int FIFO_AW = 4
) (
    input  logic         sysclk,
    input  logic         nsysreset,
    lcd_uart_tx_if.slave bus
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int BW    = $clog2(CLK_DIV);
    localparam logic [BW-1:0]    BAUD_RELOAD = BW'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0] FULL_COUNT  = (FIFO_AW + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               ovf;
    logic [1:0]         state;
    logic [BW-1:0]      baud_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift_reg;
    logic               txd;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign push  = bus.wr_en && !full;
    // A frame is loaded from idle, or straight out of a finished stop bit.
    assign pop   = !empty && ((state == ST_IDLE) ||
                              (state == ST_STOP && baud_cnt == '0));

    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.count = count;
    assign bus.ovf   = ovf;
    assign bus.busy  = (state != ST_IDLE);
    assign bus.txd   = txd;

    always_ff @(posedge sysclk) begin
        if (push)
            mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge sysclk or negedge nsysreset) begin
        if (!nsysreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A fresh overflow outranks a simultaneous clear.
            if (bus.wr_en && full)
                ovf <= 1'b1;
            else if (bus.clr_ovf)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge nsysreset) begin
        if (!nsysreset) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            txd       <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
                        baud_cnt  <= BAUD_RELOAD;
                        txd       <= 1'b0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        bit_idx  <= '0;
                        txd      <= shift_reg[0];
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            txd       <= shift_reg[1];
                            bit_idx   <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == '0) begin
                        if (pop) begin
                            shift_reg <= mem[rd_ptr];
                            baud_cnt  <= BAUD_RELOAD;
                            txd       <= 1'b0;
                            state     <= ST_START;
                        end else begin
                            txd   <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_uart_tx.sv
// Directed bench for lcd_uart_tx: a fast-baud instance for framing, FIFO and
// reset behaviour, plus a 1042-clock instance for real bit timing.
module tb_lcd_uart_tx;
    localparam int CLK_DIV = 4;
    localparam int FIFO_AW = 2;
    localparam int SLOW_DIV = 1042;

    logic clk = 1'b0;
    logic rst_n;
    int   testsRun = 0;
    int   testsFailed = 0;

    logic [7:0] rxBytes [5];
    int         rxWaits [5];
    bit         rxOk [5];
    bit         flag;
    int         runLen;

    lcd_uart_tx_if #(.FIFO_AW(FIFO_AW)) bus ();
    lcd_uart_tx_if #(.FIFO_AW(FIFO_AW)) bus2 ();

    lcd_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .sysclk(clk),
        .nsysreset(rst_n),
        .bus(bus.slave)
    );

    lcd_uart_tx #(.CLK_DIV(SLOW_DIV), .FIFO_AW(FIFO_AW)) dut2 (
        .sysclk(clk),
        .nsysreset(rst_n),
        .bus(bus2.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One push on the next rising edge; returns at the negedge after it.
    task automatic applyStimulus(input logic [7:0] data);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // Waits for a start bit, then samples every clock of all ten bit cells.
    task automatic receiveFrame(output logic [7:0] data, output int waited, output bit ok);
        logic [9:0] bits;
        bit stable;
        waited = 0;
        stable = 1'b1;
        bits   = '1;
        while (bus.txd !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (bus.txd !== 1'b0) begin
            ok = 1'b0;
        end else begin
            for (int i = 0; i < 10; i++) begin
                for (int c = 0; c < CLK_DIV; c++) begin
                    if (i != 0 || c != 0)
                        @(negedge clk);
                    if (c == 0)
                        bits[i] = bus.txd;
                    else if (bus.txd !== bits[i])
                        stable = 1'b0;
                    if (bus.busy !== 1'b1)
                        stable = 1'b0;
                end
            end
            ok = stable && (bits[0] == 1'b0) && (bits[9] == 1'b1);
        end
        data = bits[8:1];
    endtask

    task automatic measureRun(input logic level, input int limit, output int n);
        n = 0;
        while (bus2.txd === level && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.clr_ovf  = 1'b0;
        bus2.wr_en   = 1'b0;
        bus2.wr_data = '0;
        bus2.clr_ovf = 1'b0;
        rst_n = 1'b0;

        // Reset state and idle line.
        repeat (3) @(negedge clk);
        checkOutput("rst_txd",   32'(bus.txd),   32'd1);
        checkOutput("rst_busy",  32'(bus.busy),  32'd0);
        checkOutput("rst_empty", 32'(bus.empty), 32'd1);
        checkOutput("rst_full",  32'(bus.full),  32'd0);
        checkOutput("rst_count", 32'(bus.count), 32'd0);
        checkOutput("rst_ovf",   32'(bus.ovf),   32'd0);
        rst_n = 1'b1;
        flag = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (bus.txd !== 1'b1 || bus.busy !== 1'b0 || bus.empty !== 1'b1) flag = 1'b0;
        end
        checkOutput("idle50_quiet", 32'(flag), 32'd1);

        // Single byte 0x55: latency, framing and busy width.
        applyStimulus(8'h55);
        checkOutput("t2_empty_after_push", 32'(bus.empty), 32'd0);
        checkOutput("t2_count_after_push", 32'(bus.count), 32'd1);
        checkOutput("t2_txd_before_start", 32'(bus.txd),   32'd1);
        @(negedge clk);
        receiveFrame(rxBytes[0], rxWaits[0], rxOk[0]);
        checkOutput("t2_start_latency", 32'(rxWaits[0]), 32'd0);
        checkOutput("t2_frame_ok",      32'(rxOk[0]),    32'd1);
        checkOutput("t2_byte",          32'(rxBytes[0]), 32'h55);
        @(negedge clk);
        checkOutput("t2_busy_end",  32'(bus.busy),  32'd0);
        checkOutput("t2_empty_end", 32'(bus.empty), 32'd1);
        checkOutput("t2_txd_end",   32'(bus.txd),   32'd1);

        // Three back-to-back bytes: contiguous frames in push order.
        repeat (5) @(negedge clk);
        fork
            begin
                bus.wr_en = 1'b1;
                bus.wr_data = 8'h41;
                @(negedge clk) bus.wr_data = 8'h42;
                @(negedge clk) bus.wr_data = 8'h43;
                @(negedge clk) bus.wr_en = 1'b0;
            end
            begin
                for (int f = 0; f < 3; f++)
                    receiveFrame(rxBytes[f], rxWaits[f], rxOk[f]);
            end
        join
        checkOutput("t3_ok0",   32'(rxOk[0]),    32'd1);
        checkOutput("t3_byte0", 32'(rxBytes[0]), 32'h41);
        checkOutput("t3_ok1",   32'(rxOk[1]),    32'd1);
        checkOutput("t3_byte1", 32'(rxBytes[1]), 32'h42);
        checkOutput("t3_gap1",  32'(rxWaits[1]), 32'd1);
        checkOutput("t3_ok2",   32'(rxOk[2]),    32'd1);
        checkOutput("t3_byte2", 32'(rxBytes[2]), 32'h43);
        checkOutput("t3_gap2",  32'(rxWaits[2]), 32'd1);
        @(negedge clk);
        checkOutput("t3_busy_end", 32'(bus.busy), 32'd0);

        // Overflow: six pushes into a four-deep FIFO, then clear handling.
        repeat (5) @(negedge clk);
        fork
            begin
                bus.wr_en = 1'b1;
                bus.wr_data = 8'h10;
                for (int i = 1; i < 6; i++) begin
                    @(negedge clk);
                    bus.wr_data = 8'h10 + 8'(i);
                end
                @(negedge clk);
                checkOutput("t4_full",  32'(bus.full),  32'd1);
                checkOutput("t4_count", 32'(bus.count), 32'd4);
                checkOutput("t4_ovf",   32'(bus.ovf),   32'd1);
                bus.wr_data = 8'h16;
                bus.clr_ovf = 1'b1;
                @(negedge clk);
                checkOutput("t4_ovf_clr_vs_new", 32'(bus.ovf),   32'd1);
                checkOutput("t4_count_dropped",  32'(bus.count), 32'd4);
                bus.wr_en = 1'b0;
                @(negedge clk);
                checkOutput("t4_ovf_cleared", 32'(bus.ovf), 32'd0);
                bus.clr_ovf = 1'b0;
            end
            begin
                for (int f = 0; f < 5; f++)
                    receiveFrame(rxBytes[f], rxWaits[f], rxOk[f]);
            end
        join
        for (int f = 0; f < 5; f++) begin
            checkOutput($sformatf("t4_ok%0d", f),   32'(rxOk[f]),    32'd1);
            checkOutput($sformatf("t4_byte%0d", f), 32'(rxBytes[f]), 32'h10 + 32'(f));
            if (f > 0)
                checkOutput($sformatf("t4_gap%0d", f), 32'(rxWaits[f]), 32'd1);
        end
        flag = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (bus.txd !== 1'b1 || bus.busy !== 1'b0) flag = 1'b0;
        end
        checkOutput("t4_no_sixth_frame", 32'(flag), 32'd1);

        // Reset in the middle of 0xA5 data bit 1 with two bytes queued.
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hA5;
        @(negedge clk) bus.wr_data = 8'h01;
        @(negedge clk) bus.wr_data = 8'h02;
        @(negedge clk) bus.wr_en = 1'b0;
        checkOutput("t5_queued", 32'(bus.count), 32'd2);
        repeat (8) @(negedge clk);
        checkOutput("t5_txd_bit1_low", 32'(bus.txd), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_txd_async", 32'(bus.txd),   32'd1);
        checkOutput("t5_busy",      32'(bus.busy),  32'd0);
        checkOutput("t5_count",     32'(bus.count), 32'd0);
        checkOutput("t5_empty",     32'(bus.empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (bus.txd !== 1'b1 || bus.busy !== 1'b0) flag = 1'b0;
        end
        checkOutput("t5_no_frames_after", 32'(flag), 32'd1);

        // Real baud rate: 0x0D at 1042 clocks per bit.
        @(negedge clk);
        bus2.wr_en = 1'b1;
        bus2.wr_data = 8'h0D;
        @(negedge clk);
        bus2.wr_en = 1'b0;
        @(negedge clk);
        checkOutput("t6_start_low", 32'(bus2.txd), 32'd0);
        measureRun(1'b0, 5000, runLen);
        checkOutput("t6_start_len", 32'(runLen), 32'(SLOW_DIV));
        measureRun(1'b1, 5000, runLen);
        checkOutput("t6_bit0_len", 32'(runLen), 32'(SLOW_DIV));
        measureRun(1'b0, 5000, runLen);
        checkOutput("t6_bit1_len", 32'(runLen), 32'(SLOW_DIV));
        measureRun(1'b1, 5000, runLen);
        checkOutput("t6_bit23_len", 32'(runLen), 32'(2 * SLOW_DIV));
        measureRun(1'b0, 5000, runLen);
        checkOutput("t6_bit4567_len", 32'(runLen), 32'(4 * SLOW_DIV));
        repeat (SLOW_DIV - 1) @(negedge clk);
        checkOutput("t6_stop_busy", 32'(bus2.busy), 32'd1);
        checkOutput("t6_stop_txd",  32'(bus2.txd),  32'd1);
        @(negedge clk);
        checkOutput("t6_idle_busy", 32'(bus2.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
